// File: rtl/parser_pkg.sv
// Shared parser-pipeline types and constants for the rule configuration master.
package parser_pkg;

    localparam int unsigned LAYER_NUM         = 4;
    localparam int unsigned LAYER_IDX_W       = 3;
    localparam int unsigned RULE_CFG_TIMEOUT  = 16;
    localparam int unsigned CFG_LAYER_FIELD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } cfg_state_e;

    typedef struct packed {
        logic                         wr;
        logic [CFG_LAYER_FIELD_W-1:0] layer;
        logic [31:0]                  addr;
        logic [31:0]                  wdata;
    } cfg_cmd_t;

endpackage

// File: rtl/rule_cfg_master.sv
// Host-to-parser-layer rule configuration initiator, one transaction outstanding at a time.
// Optional broadcast writes to all layers are enabled by defining RULE_CFG_BCAST_EN.
module rule_cfg_master #(
    parameter int unsigned LAYER_NUM      = parser_pkg::LAYER_NUM,
    parameter int unsigned LAYER_IDX_W    = parser_pkg::LAYER_IDX_W,
    parameter int unsigned TIMEOUT_CYCLES = parser_pkg::RULE_CFG_TIMEOUT
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_wr,
    input  logic [LAYER_IDX_W-1:0]  i_cmd_layer,
    input  logic [31:0]             i_cmd_addr,
    input  logic [31:0]             i_cmd_wdata,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [31:0]             o_resp_rdata,
    output logic                    o_resp_err,
    output logic [LAYER_NUM-1:0]    o_rule_wren,
    output logic [LAYER_NUM-1:0]    o_rule_rden,
    output logic [31:0]             o_rule_addr,
    output logic [31:0]             o_rule_wdata,
    input  logic [LAYER_NUM-1:0]    i_rule_rdata_valid,
    input  logic [LAYER_NUM*32-1:0] i_rule_rdata
);

    import parser_pkg::*;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [CFG_LAYER_FIELD_W-1:0] BCAST_CODE =
        CFG_LAYER_FIELD_W'({LAYER_IDX_W{1'b1}});

    cfg_state_e state_q, state_d;
    cfg_cmd_t   cmd_q, cmd_d;
    logic [7:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        cmd_ready_q, resp_valid_q;
    logic [LAYER_NUM-1:0] wren_q, rden_q;
    logic [LAYER_NUM-1:0] sel_q, sel_d;
    logic [31:0] rd_mux;
    logic        rd_hit;
    logic        in_layer_ok, in_bcast;

    assign in_layer_ok = (32'(i_cmd_layer) < LAYER_NUM);
`ifdef RULE_CFG_BCAST_EN
    assign in_bcast = (i_cmd_layer == {LAYER_IDX_W{1'b1}});
`else
    assign in_bcast = 1'b0;
`endif

    // One-hot layer select for the latched (sel_q) and incoming (sel_d) command.
    always_comb begin
        sel_q = '0;
        sel_d = '0;
        for (int i = 0; i < LAYER_NUM; i++) begin
            sel_q[i] = (cmd_q.layer == CFG_LAYER_FIELD_W'(i));
            sel_d[i] = (cmd_d.layer == CFG_LAYER_FIELD_W'(i));
        end
`ifdef RULE_CFG_BCAST_EN
        if (cmd_q.layer == BCAST_CODE) sel_q = '1;
        if (cmd_d.layer == BCAST_CODE) sel_d = '1;
`endif
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < LAYER_NUM; i++) begin
            if (sel_q[i]) rd_mux = rd_mux | i_rule_rdata[i*32 +: 32];
        end
    end

    // Other layers' valids are masked off by the select.
    assign rd_hit = |(i_rule_rdata_valid & sel_q);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    cmd_d.wr    = i_cmd_wr;
                    cmd_d.layer = CFG_LAYER_FIELD_W'(i_cmd_layer);
                    cmd_d.addr  = i_cmd_addr;
                    cmd_d.wdata = i_cmd_wdata;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    if (in_layer_ok || (in_bcast && i_cmd_wr)) begin
                        state_d = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                if (cmd_q.wr) begin
                    state_d = RESP;
                end else if (rd_hit) begin
                    rdata_d = rd_mux;
                    state_d = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (rd_hit) begin
                    rdata_d = rd_mux;
                    state_d = RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (i_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so strobes line up with the ISSUE cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            wren_q       <= '0;
            rden_q       <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cmd_ready_q  <= (state_d == IDLE);
            resp_valid_q <= (state_d == RESP);
            wren_q       <= (state_d == ISSUE &&  cmd_d.wr) ? sel_d : '0;
            rden_q       <= (state_d == ISSUE && !cmd_d.wr) ? sel_d : '0;
        end
    end

    assign o_cmd_ready  = cmd_ready_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;
    assign o_rule_wren  = wren_q;
    assign o_rule_rden  = rden_q;
    assign o_rule_addr  = cmd_q.addr;
    assign o_rule_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_rule_cfg_master.sv
// Directed self-checking bench for rule_cfg_master (4 layers, 16-cycle read timeout).
module tb_rule_cfg_master;

    localparam int unsigned LN = 4;
    localparam int unsigned LW = 3;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [LW-1:0] cmd_layer = '0;
    logic [31:0]   cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [LN-1:0] rule_wren, rule_rden;
    logic [31:0]   rule_addr, rule_wdata;
    logic [LN-1:0] rule_rdata_valid;
    logic [LN*32-1:0] rule_rdata;

    // Layer model: answers in the strobe cycle for layers in resp_mask; extra_valid injects
    // stray or late valids.
    logic [LN-1:0] resp_mask = '0;
    logic [LN-1:0] extra_valid = '0;
    assign rule_rdata_valid = (rule_rden & resp_mask) | extra_valid;
    assign rule_rdata = {32'hCAFE_3333, 32'h1234_5678, 32'hBEEF_1111, 32'hDEAD_0000};

    int tests = 0;
    int fails = 0;
    int seen;

    always #5 clk = ~clk;

    rule_cfg_master #(
        .LAYER_NUM(LN),
        .LAYER_IDX_W(LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_wr(cmd_wr),
        .i_cmd_layer(cmd_layer),
        .i_cmd_addr(cmd_addr),
        .i_cmd_wdata(cmd_wdata),
        .o_resp_valid(resp_valid),
        .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata),
        .o_resp_err(resp_err),
        .o_rule_wren(rule_wren),
        .o_rule_rden(rule_rden),
        .o_rule_addr(rule_addr),
        .o_rule_wdata(rule_wdata),
        .i_rule_rdata_valid(rule_rdata_valid),
        .i_rule_rdata(rule_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    // Present a command at a negedge; the following posedge accepts it.
    task automatic send(input logic wr, input logic [LW-1:0] layer, input logic [31:0] addr,
                        input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_layer = layer;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        next();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        next();
        next();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_wren", 64'(rule_wren), 64'd0);
        check("rst_rden", 64'(rule_rden), 64'd0);
        check("rst_addr", 64'(rule_addr), 64'd0);
        check("rst_wdata", 64'(rule_wdata), 64'd0);
        rst = 1'b0;
        next();

        // Write layer 1
        send(1'b1, 3'd1, 32'h0000_0010, 32'hA5A5_0001);
        check("wr_wren", 64'(rule_wren), 64'h2);
        check("wr_rden", 64'(rule_rden), 64'h0);
        check("wr_addr", 64'(rule_addr), 64'h10);
        check("wr_wdata", 64'(rule_wdata), 64'hA5A5_0001);
        check("wr_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        check("wr_no_early_resp", 64'(resp_valid), 64'd0);
        next();
        check("wr_wren_one_cycle", 64'(rule_wren), 64'h0);
        check("wr_resp_valid", 64'(resp_valid), 64'd1);
        check("wr_resp", 64'({resp_err, resp_rdata}), 64'h0);
        next();
        check("wr_resp_done", 64'(resp_valid), 64'd0);
        check("wr_ready_back", 64'(cmd_ready), 64'd1);

        // Read layer 2 answered in the strobe cycle
        resp_mask = 4'b0100;
        send(1'b0, 3'd2, 32'h0000_0020, 32'h0);
        check("rd2_rden", 64'(rule_rden), 64'h4);
        next();
        check("rd2_resp_valid", 64'(resp_valid), 64'd1);
        check("rd2_resp", 64'({resp_err, resp_rdata}), {31'd0, 1'b0, 32'h1234_5678});
        next();
        resp_mask = '0;

        // Read layer 0 with no answer; a stray valid on layer 1 must be ignored
        extra_valid = 4'b0010;
        send(1'b0, 3'd0, 32'h0000_0030, 32'h0);
        check("to_rden", 64'(rule_rden), 64'h1);
        next();
        check("to_rden_off_in_wait", 64'(rule_rden), 64'h0);
        for (int i = 2; i <= int'(TO); i++) next();
        check("to_not_yet", 64'(resp_valid), 64'd0);
        next();
        check("to_resp_valid", 64'(resp_valid), 64'd1);
        check("to_resp", 64'({resp_err, resp_rdata}), {31'd0, 1'b1, 32'h0});
        next();
        extra_valid = 4'b0001;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            next();
            if (resp_valid) seen++;
        end
        check("to_late_valid_ignored", 64'(seen), 64'd0);
        extra_valid = '0;

        // Out-of-range layer: immediate error, no strobe
        send(1'b0, 3'd5, 32'h0000_0040, 32'h0);
        check("bad_strobes", 64'({rule_wren, rule_rden}), 64'h0);
        check("bad_resp_valid", 64'(resp_valid), 64'd1);
        check("bad_resp", 64'({resp_err, resp_rdata}), {31'd0, 1'b1, 32'h0});
        next();

        // All-ones layer code
        send(1'b1, 3'd7, 32'h0000_0050, 32'h5555_AAAA);
`ifdef RULE_CFG_BCAST_EN
        check("bc_wr_wren", 64'(rule_wren), 64'hF);
        next();
        check("bc_wr_resp_valid", 64'(resp_valid), 64'd1);
        check("bc_wr_resp", 64'({resp_err, resp_rdata}), 64'h0);
`else
        check("l7_wr_strobes", 64'({rule_wren, rule_rden}), 64'h0);
        check("l7_wr_resp_valid", 64'(resp_valid), 64'd1);
        check("l7_wr_err", 64'(resp_err), 64'd1);
`endif
        next();
        send(1'b0, 3'd7, 32'h0000_0060, 32'h0);
        check("l7_rd_strobes", 64'({rule_wren, rule_rden}), 64'h0);
        check("l7_rd_resp_valid", 64'(resp_valid), 64'd1);
        check("l7_rd_err", 64'(resp_err), 64'd1);
        next();

        // Back-to-back commands while the host stalls the response
        resp_ready = 1'b0;
        resp_mask  = 4'b0100;
        send(1'b1, 3'd3, 32'h0000_0070, 32'h7777_0003);
        check("bb_wren", 64'(rule_wren), 64'h8);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_layer = 3'd2;
        cmd_addr  = 32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            next();
            check("bb_stall_ready", 64'(cmd_ready), 64'd0);
            check("bb_stall_resp", 64'({resp_valid, resp_err, resp_rdata}), {30'd0, 2'b10, 32'h0});
        end
        resp_ready = 1'b1;
        next();
        check("bb_handshake_ready", 64'(cmd_ready), 64'd1);
        check("bb_handshake_valid", 64'(resp_valid), 64'd0);
        next();
        cmd_valid = 1'b0;
        check("bb_second_rden", 64'(rule_rden), 64'h4);
        check("bb_second_addr", 64'(rule_addr), 64'h80);
        next();
        check("bb_second_resp", 64'({resp_valid, resp_err, resp_rdata}),
              {30'd0, 2'b10, 32'h1234_5678});
        next();
        resp_mask = '0;

        // Reset during WAIT_RD
        send(1'b0, 3'd0, 32'h0000_0090, 32'h0);
        next();
        next();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_outs", 64'({resp_valid, resp_err, rule_wren, rule_rden}), 64'h0);
        check("mid_rst_bus", 64'({rule_addr, rule_wdata}), 64'h0);
        next();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < int'(TO) + 6; i++) begin
            next();
            if (resp_valid || !cmd_ready) seen++;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
